// File: rtl/mul_sequencer.sv
// Sequences an external shift-add multiplier: clear, operand load, 32 MULTU
// iterations, result transfer, then capture of the 64-bit product into hi/lo.
module mul_sequencer #(
  parameter logic [5:0] MULTU = 6'b011001,
  parameter logic [5:0] OUT   = 6'b111111,
  parameter logic [5:0] NOP   = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [5:0]  mul_signal,
  output logic        mul_reset,
  output logic [31:0] mul_dataA,
  output logic [31:0] mul_dataB,
  input  logic [63:0] mul_dataOut
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_RUN     = 3'd3,
    S_XFER    = 3'd4,
    S_CAPTURE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        err_q, err_d;

  // State, operand, result and error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and multiplier control decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    err_d      = 1'b0;
    mul_signal = NOP;
    mul_dataA  = a_q;
    mul_dataB  = b_q;
    case (state_q)
      S_IDLE: begin
        if (start && (funct == MULTU)) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = S_CLEAR;
        end else if (start) begin
          err_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        // Inverted operands force the multiplier to see a change on LOAD
        mul_dataA = ~a_q;
        mul_dataB = ~b_q;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = 5'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        mul_signal = MULTU;
        if (cnt_q == 5'd31) begin
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_XFER: begin
        mul_signal = OUT;
        state_d    = S_CAPTURE;
      end
      S_CAPTURE: begin
        hi_d    = mul_dataOut[63:32];
        lo_d    = mul_dataOut[31:0];
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign mul_reset = reset | (state_q == S_CLEAR);

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: a timeline model of one operation plus a behavioural
// shift-add multiplier, compared against the DUT on every falling edge.
module tb_mul_sequencer;

  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] OUT   = 6'b111111;
  localparam logic [5:0] NOP   = 6'b000000;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b;
  logic        busy, done, err;
  logic [31:0] hi, lo;
  logic [5:0]  mul_signal;
  logic        mul_reset;
  logic [31:0] mul_dataA, mul_dataB;
  logic [63:0] mul_dataOut;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .err(err),
    .hi(hi), .lo(lo), .mul_signal(mul_signal), .mul_reset(mul_reset),
    .mul_dataA(mul_dataA), .mul_dataB(mul_dataB), .mul_dataOut(mul_dataOut)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural multiplier: latches operands when they change, counts MULTU
  // steps and only yields the true product after exactly 32 of them.
  logic [31:0] m_a, m_b;
  int          m_iter;
  always @(posedge clk) begin
    if (mul_reset) begin
      m_a <= 32'd0; m_b <= 32'd0; m_iter <= 0; mul_dataOut <= 64'd0;
    end else begin
      if (mul_dataA != m_a) m_a <= mul_dataA;
      if (mul_dataB != m_b) m_b <= mul_dataB;
      if (mul_signal == MULTU) m_iter <= m_iter + 1;
      if (mul_signal == OUT)
        mul_dataOut <= (m_iter == 32) ? {32'd0, m_a} * {32'd0, m_b} : 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  // Timeline model: k = cycles since the accepting edge (0 = idle).
  // k=1 clear, 2 load, 3..34 iterate, 35 transfer, 36 capture, 37 done.
  int          k = 0;
  logic [31:0] e_a, e_b;
  logic [63:0] e_prod;
  logic        e_err, model_valid = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      k <= 0; e_a <= 32'd0; e_b <= 32'd0; e_prod <= 64'd0; e_err <= 1'b0;
      model_valid <= 1'b1;
    end else begin
      e_err <= (k == 0) && start && (funct != MULTU);
      if (k == 0) begin
        if (start && funct == MULTU) begin
          k <= 1; e_a <= op_a; e_b <= op_b;
        end
      end else if (k == 37) k <= 0;
      else k <= k + 1;
      if (k == 36) e_prod <= {32'd0, e_a} * {32'd0, e_b};
    end
  end

  // Per-cycle comparison against the model
  int mcount = 0;
  always @(negedge clk) begin
    if (model_valid) begin
      chk("busy", {63'd0, busy}, {63'd0, k != 0});
      chk("done", {63'd0, done}, {63'd0, k == 37});
      chk("err", {63'd0, err}, {63'd0, e_err});
      chk("done_err_excl", {63'd0, done & err}, 64'd0);
      chk("hilo", {hi, lo}, e_prod);
      chk("mul_signal", {58'd0, mul_signal},
          {58'd0, (k >= 3 && k <= 34) ? MULTU : ((k == 35) ? OUT : NOP)});
      chk("mul_reset", {63'd0, mul_reset}, {63'd0, reset || k == 1});
      chk("mul_dataA", {32'd0, mul_dataA}, {32'd0, (k == 1) ? ~e_a : e_a});
      chk("mul_dataB", {32'd0, mul_dataB}, {32'd0, (k == 1) ? ~e_b : e_b});
      if (reset) mcount = 0;
      else if (mul_signal == MULTU) mcount++;
      if (done) begin
        chk("multu_count", mcount, 64'd32);
        mcount = 0;
      end
    end
  end

  // Caller is at a falling edge; returns at the next one (start then deasserted).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    start = 1'b1; funct = f; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 64'd0, 64'd1);
  endtask

  int n;
  initial begin
    reset = 1'b1; start = 1'b0; funct = NOP; op_a = 32'd0; op_b = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_sig", {58'd0, mul_signal}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 3*5; start driven in cycle 0, done expected in cycle 37
    start_op(32'd3, 32'd5, MULTU);
    wait_done(n);
    chk("done_cycle", n + 1, 64'd37);
    chk("res_3x5", {hi, lo}, 64'h0000_0000_0000_000F);
    @(negedge clk);

    // All-ones times two, then identical operands again
    for (int r = 0; r < 2; r++) begin
      start_op(32'hFFFF_FFFF, 32'd2, MULTU);
      wait_done(n);
      chk("res_ff_x2", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
      @(negedge clk);
    end

    // Unsupported funct
    start_op(32'd7, 32'd7, 6'b011000);
    chk("err_pulse", {63'd0, err}, 64'd1);
    chk("err_busy", {63'd0, busy}, 64'd0);
    chk("err_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    @(negedge clk);
    chk("err_one_cycle", {63'd0, err}, 64'd0);

    // Starts while busy are ignored
    start_op(32'd11, 32'd13, MULTU);
    repeat (4) @(negedge clk);
    start_op(32'd99, 32'd99, MULTU);
    repeat (14) @(negedge clk);
    start_op(32'd50, 32'd50, 6'b000001);
    wait_done(n);
    chk("res_ignore", {hi, lo}, 64'd143);
    @(negedge clk);
    chk("no_second_done", {63'd0, done | busy}, 64'd0);

    // Reset while iterating at counter 10 (k=13), then 7*9 right after
    start_op(32'd1234, 32'd5678, MULTU);
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    start_op(32'd7, 32'd9, MULTU);
    chk("restart_busy", {63'd0, busy}, 64'd1);
    wait_done(n);
    chk("res_7x9", {hi, lo}, 64'd63);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
